// File: rtl/hi_register_pkg.sv
// hi_register_pkg: shared constants and helpers for the HI/LO special registers.
//   DATA_W     - CPU data width used as the default register width.
//   wr_sel()   - write-select rule: a register write needs both the unit's
//                write enable and the CPU-wide step enable.
package hi_register_pkg;

    localparam int DATA_W = 32;

    function automatic logic wr_sel(input logic wren, input logic step);
        return wren & step;
    endfunction

endpackage

// File: rtl/dff_async_rst.sv
// dff_async_rst: generic enabled D flip-flop bank with async active-low reset.
// Shared by the HI, LO and PC registers.
//   clk    - rising-edge clock
//   reset  - asynchronous, active-low; forces q to RESET_VALUE
//   en     - load enable; q holds when low
//   d      - next value
//   q      - registered value (pure flop output)
module dff_async_rst #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            q <= RESET_VALUE;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/hi_register.sv
// hi_register: MIPS HI special-purpose register.
// Loads every rising edge: MTHI/write data when both enables are high,
// otherwise the fed-back HI value (hi_readdata itself or the mult/div result).
//   clk          - rising-edge clock
//   reset        - asynchronous, active-low; clears to RESET_VALUE
//   hi_wren      - HI write enable from control
//   clk_enable   - CPU-wide step enable
//   read_data_a  - write data (register-file port A)
//   hi           - current HI value fed back from the datapath
//   hi_readdata  - registered HI contents
module hi_register
    import hi_register_pkg::*;
#(
    parameter int               WIDTH       = DATA_W,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hi_wren,
    input  logic             clk_enable,
    input  logic [WIDTH-1:0] read_data_a,
    input  logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] hi_readdata
);

    logic [WIDTH-1:0] next_hi;

    // The hold behaviour comes from the external feedback on `hi`, so the
    // flop itself loads unconditionally.
    always_comb begin
        next_hi = hi;
        if (wr_sel(hi_wren, clk_enable))
            next_hi = read_data_a;
    end

    dff_async_rst #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_hi_ff (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .d     (next_hi),
        .q     (hi_readdata)
    );

endmodule

// File: tb/tb_hi_register.sv
// tb_hi_register: directed + short random check of hi_register.
module tb_hi_register;

    logic        clk = 1'b0;
    logic        reset;
    logic        hi_wren;
    logic        clk_enable;
    logic [31:0] read_data_a;
    logic [31:0] hi_drv;
    logic        fb_mode;
    logic [31:0] hi;
    logic [31:0] hi_readdata;

    int n_chk  = 0;
    int n_pass = 0;

    assign hi = fb_mode ? hi_readdata : hi_drv;

    always #5 clk = ~clk;

    hi_register dut (
        .clk         (clk),
        .reset       (reset),
        .hi_wren     (hi_wren),
        .clk_enable  (clk_enable),
        .read_data_a (read_data_a),
        .hi          (hi),
        .hi_readdata (hi_readdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h exp %h", tag, got, exp);
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic e, input logic [31:0] a, input logic [31:0] h);
        hi_wren     = w;
        clk_enable  = e;
        read_data_a = a;
        hi_drv      = h;
    endtask

    logic [31:0] exp_q;

    initial begin
        fb_mode = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b0;
        #2;
        chk("reset_init", hi_readdata, 32'h0);
        tick();
        reset = 1'b1;

        // load a known value, then assert reset mid-cycle
        drive(1'b1, 1'b1, 32'hDEADBEEF, 32'h0);
        tick();
        chk("load_deadbeef", hi_readdata, 32'hDEADBEEF);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset", hi_readdata, 32'h0);
        tick();
        chk("reset_hold1", hi_readdata, 32'h0);
        tick();
        chk("reset_hold2", hi_readdata, 32'h0);
        reset = 1'b1;

        // write selects read_data_a
        drive(1'b1, 1'b1, 32'h12345678, 32'hAAAAAAAA);
        tick();
        chk("write", hi_readdata, 32'h12345678);

        // either enable low selects hi
        drive(1'b1, 1'b0, 32'h12345678, 32'h0000FFFF);
        tick();
        chk("gated_step", hi_readdata, 32'h0000FFFF);
        drive(1'b1, 1'b1, 32'h0BADF00D, 32'h0);
        tick();
        chk("rewrite", hi_readdata, 32'h0BADF00D);
        drive(1'b0, 1'b1, 32'h12345678, 32'h0000FFFF);
        tick();
        chk("gated_wren", hi_readdata, 32'h0000FFFF);
        drive(1'b0, 1'b0, 32'h12345678, 32'h00FF00FF);
        tick();
        chk("both_low", hi_readdata, 32'h00FF00FF);

        // back-to-back writes
        drive(1'b1, 1'b1, 32'h11111111, 32'h0);
        tick();
        chk("b2b_0", hi_readdata, 32'h11111111);
        drive(1'b1, 1'b1, 32'h22222222, 32'h0);
        tick();
        chk("b2b_1", hi_readdata, 32'h22222222);

        // feedback hold
        fb_mode = 1'b1;
        drive(1'b1, 1'b1, 32'hCAFEF00D, 32'h0);
        tick();
        chk("fb_load", hi_readdata, 32'hCAFEF00D);
        drive(1'b0, 1'b1, 32'h55555555, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("fb_hold", hi_readdata, 32'hCAFEF00D);
        end
        fb_mode = 1'b0;

        // reset overrides a write across an edge
        drive(1'b1, 1'b1, 32'hFFFFFFFF, 32'h0);
        reset = 1'b0;
        #1;
        chk("rst_prio_async", hi_readdata, 32'h0);
        tick();
        chk("rst_prio_edge", hi_readdata, 32'h0);
        reset = 1'b1;
        tick();
        chk("rst_release", hi_readdata, 32'hFFFFFFFF);

        // random with shadow model
        exp_q = 32'hFFFFFFFF;
        for (int i = 0; i < 100; i++) begin
            drive(1'($urandom_range(1)), 1'($urandom_range(1)), $urandom, $urandom);
            reset = ($urandom_range(99) == 0) ? 1'b0 : 1'b1;
            #1;
            if (!reset) begin
                exp_q = 32'h0;
                chk("rnd_async_rst", hi_readdata, exp_q);
            end else if (hi_wren && clk_enable) begin
                exp_q = read_data_a;
            end else begin
                exp_q = hi_drv;
            end
            tick();
            chk("rnd", hi_readdata, exp_q);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
